// File: rtl/snoop_resp_pkg.sv
// Shared snoop-response types and constants.
// Provides the CRRESP bit packing, the queued entry type (CR + full line),
// beat geometry for serialising a line onto the CD channel, the head FSM
// state encoding and a helper that extracts one CD beat from a line.
package snoop_resp_pkg;

  localparam int LINE_WIDTH    = 128;
  localparam int CD_DATA_WIDTH = 64;
  localparam int NUM_BEATS     = LINE_WIDTH / CD_DATA_WIDTH;
  localparam int BEAT_W        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  // Position of dataTransfer inside the packed CRRESP vector.
  localparam int CR_DT_BIT     = 0;

  // Field order matches the port packing, MSB first.
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    crresp_t               cr;
    logic [LINE_WIDTH-1:0] data;
  } snoop_resp_entry_t;

  // Line viewed as beats; element 0 is the low word and goes out first.
  typedef logic [NUM_BEATS-1:0][CD_DATA_WIDTH-1:0] line_beats_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_CR = 2'd1,
    ST_SEND_CD = 2'd2
  } head_state_t;

  function automatic logic [CD_DATA_WIDTH-1:0] line_beat(
    input logic [LINE_WIDTH-1:0] line,
    input logic [BEAT_W-1:0]     beat
  );
    line_beats_t beats;
    beats = line_beats_t'(line);
    return beats[beat];
  endfunction

endpackage

// File: rtl/snoop_resp_fifo.sv
// Circular FIFO of snoop_resp_entry_t.
// Ports: clk/rst (sync, active-high); push + push_entry write at wr_ptr;
// pop advances rd_ptr; peek shows the head, or the entry behind it when
// peek_next is set (lets the consumer load its successor while popping);
// full/empty/count are registered occupancy flags.
// Pointers wrap modulo DEPTH (DEPTH must be a power of two).
module snoop_resp_fifo
  import snoop_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  snoop_resp_entry_t      push_entry,
  input  logic                   pop,
  input  logic                   peek_next,
  output snoop_resp_entry_t      peek,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  snoop_resp_entry_t mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  peek_ptr;
  logic [CNT_W-1:0]  count_nxt;

  // Read port select and next occupancy.
  always_comb begin
    if (peek_next) begin
      peek_ptr = rd_ptr + PTR_W'(1);
    end else begin
      peek_ptr = rd_ptr;
    end
    peek = mem[peek_ptr];
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and registered occupancy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_W'(0);
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == CNT_W'(0));
    end
  end

endmodule

// File: rtl/snoop_resp_buffer.sv
// Snoop response buffer between the snoop cache controller and the ACE
// snoop response channels. Each accepted response (CR bits + full line) is
// queued; the head is sent as one CR beat and, if dataTransfer is set, the
// line follows as NUM_BEATS CD beats, low word first.
// Ports: clk_i/rst_i (sync, active-high); resp_valid_i/resp_ready_o/
// resp_cr_i/resp_data_i from the controller; cr_valid_o/cr_ready_i/
// cr_resp_o (ACE CR); cd_valid_o/cd_ready_i/cd_data_o/cd_last_o (ACE CD);
// busy_o (queue non-empty); count_o (registered occupancy).
// Optional build macro SNOOP_RESP_CD_OVERLAP_EN: CD beats of a data entry
// are offered alongside its CR; the entry pops once both channels finish.
// Without it, CD starts only after the CR handshake.
module snoop_resp_buffer
  import snoop_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [4:0]               resp_cr_i,
  input  logic [LINE_WIDTH-1:0]    resp_data_i,
  output logic                     cr_valid_o,
  input  logic                     cr_ready_i,
  output logic [4:0]               cr_resp_o,
  output logic                     cd_valid_o,
  input  logic                     cd_ready_i,
  output logic [CD_DATA_WIDTH-1:0] cd_data_o,
  output logic                     cd_last_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  head_state_t       state;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;
  logic              beat_last;
  logic              push;
  logic              pop;
  logic              load;
  logic              avail;
  logic              cr_hs;
  logic              cd_hs;
  logic              fifo_full;
  logic              fifo_empty;
  snoop_resp_entry_t in_entry;
  snoop_resp_entry_t peek;
  snoop_resp_entry_t nxt_entry;
`ifdef SNOOP_RESP_CD_OVERLAP_EN
  logic              cr_done;
  logic              cd_done;
`endif

  assign resp_ready_o = ~fifo_full;
  assign busy_o       = ~fifo_empty;
  assign push         = resp_valid_i & resp_ready_o;
  assign in_entry     = snoop_resp_entry_t'({resp_cr_i, resp_data_i});

  snoop_resp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .peek_next  (pop),
    .peek       (peek),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (count_o)
  );

  // Handshakes, pop decision and the entry that becomes head next cycle.
  always_comb begin
    cr_hs = cr_valid_o & cr_ready_i;
    cd_hs = cd_valid_o & cd_ready_i;
`ifdef SNOOP_RESP_CD_OVERLAP_EN
    if (state == ST_SEND_CR) begin
      pop = (cr_done | cr_hs) & (cd_done | (cd_hs & cd_last_o));
    end else begin
      pop = 1'b0;
    end
`else
    if (state == ST_SEND_CR) begin
      pop = cr_hs & ~cr_resp_o[CR_DT_BIT];
    end else if (state == ST_SEND_CD) begin
      pop = cd_hs & cd_last_o;
    end else begin
      pop = 1'b0;
    end
`endif
    // IDLE implies an empty queue, so a load there can only take the
    // incoming response. After a pop, the successor is the second stored
    // entry if one exists, otherwise whatever is being pushed right now.
    load  = pop | (state == ST_IDLE);
    avail = (count_o > CNT_W'(1)) | push;
    if (count_o > CNT_W'(1)) begin
      nxt_entry = peek;
    end else begin
      nxt_entry = in_entry;
    end
    beat_nxt  = beat + BEAT_W'(1);
    beat_last = (beat_nxt == BEAT_W'(NUM_BEATS - 1));
  end

  // Head FSM with registered channel outputs and CD beat counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      beat       <= BEAT_W'(0);
      cr_valid_o <= 1'b0;
      cr_resp_o  <= 5'b0_0000;
      cd_valid_o <= 1'b0;
      cd_data_o  <= CD_DATA_WIDTH'(0);
      cd_last_o  <= 1'b0;
`ifdef SNOOP_RESP_CD_OVERLAP_EN
      cr_done    <= 1'b0;
      cd_done    <= 1'b0;
`endif
    end else if (load) begin
      if (avail) begin
        state      <= ST_SEND_CR;
        beat       <= BEAT_W'(0);
        cr_valid_o <= 1'b1;
        cr_resp_o  <= nxt_entry.cr;
        cd_last_o  <= 1'b0;
`ifdef SNOOP_RESP_CD_OVERLAP_EN
        cd_valid_o <= nxt_entry.cr.data_transfer;
        cd_data_o  <= line_beat(nxt_entry.data, BEAT_W'(0));
        cr_done    <= 1'b0;
        cd_done    <= ~nxt_entry.cr.data_transfer;
`else
        cd_valid_o <= 1'b0;
`endif
      end else begin
        state      <= ST_IDLE;
        cr_valid_o <= 1'b0;
        cd_valid_o <= 1'b0;
        cd_last_o  <= 1'b0;
      end
    end else begin
      case (state)
        ST_SEND_CR: begin
`ifdef SNOOP_RESP_CD_OVERLAP_EN
          if (cr_hs) begin
            cr_valid_o <= 1'b0;
            cr_done    <= 1'b1;
          end
          if (cd_hs) begin
            if (cd_last_o) begin
              cd_valid_o <= 1'b0;
              cd_last_o  <= 1'b0;
              cd_done    <= 1'b1;
            end else begin
              beat      <= beat_nxt;
              cd_data_o <= line_beat(peek.data, beat_nxt);
              cd_last_o <= beat_last;
            end
          end
`else
          // A CR handshake without data pops and is handled by the load path.
          if (cr_hs) begin
            state      <= ST_SEND_CD;
            cr_valid_o <= 1'b0;
            cd_valid_o <= 1'b1;
            beat       <= BEAT_W'(0);
            cd_data_o  <= line_beat(peek.data, BEAT_W'(0));
            cd_last_o  <= 1'b0;
          end
`endif
        end
        ST_SEND_CD: begin
          // The last-beat handshake pops and is handled by the load path.
          if (cd_hs) begin
            beat      <= beat_nxt;
            cd_data_o <= line_beat(peek.data, beat_nxt);
            cd_last_o <= beat_last;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_resp_buffer.sv
// Scoreboard bench for snoop_resp_buffer: accepted pushes enqueue expected
// CR values and CD beats; a monitor compares every CR/CD handshake and
// checks valid/payload stability and channel ordering.
module tb_snoop_resp_buffer;
  import snoop_resp_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     resp_valid_i = 1'b0;
  logic                     resp_ready_o;
  logic [4:0]               resp_cr_i = 5'b0;
  logic [LINE_WIDTH-1:0]    resp_data_i = '0;
  logic                     cr_valid_o;
  logic                     cr_ready_i = 1'b1;
  logic [4:0]               cr_resp_o;
  logic                     cd_valid_o;
  logic                     cd_ready_i = 1'b1;
  logic [CD_DATA_WIDTH-1:0] cd_data_o;
  logic                     cd_last_o;
  logic                     busy_o;
  logic [1:0]               count_o;

  int passed = 0;
  int total  = 0;

  logic [4:0]  cr_q[$];
  logic [64:0] cd_q[$];

  always #5 clk = ~clk;

  snoop_resp_buffer #(.DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_cr_i(resp_cr_i), .resp_data_i(resp_data_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i),
    .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .busy_o(busy_o), .count_o(count_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Offer a response until accepted; returns 1 ns after the accepting edge.
  task automatic push_resp(input logic [4:0] cr, input logic [127:0] data);
    logic r;
    bit ok;
    ok = 0;
    resp_valid_i = 1'b1; resp_cr_i = cr; resp_data_i = data;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); r = resp_ready_o;
      @(posedge clk); #1;
      if (r) ok = 1;
    end
    resp_valid_i = 1'b0;
    if (ok) begin
      cr_q.push_back(cr);
      if (cr[0]) begin
        cd_q.push_back({1'b0, data[63:0]});
        cd_q.push_back({1'b1, data[127:64]});
      end
    end
    chk("push_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy_o && !cr_valid_o && !cd_valid_o) done = 1;
    end
    chk("drain", done, 1);
    chk("sb_empty", cr_q.size() + cd_q.size(), 0);
  endtask

  // Monitor: handshake scoreboard, stability and ordering checks.
  initial begin
    logic       pcr_stall, pcd_stall, exp_last;
    logic [4:0] pcr_resp, exp_cr;
    logic [63:0] pcd_data;
    logic       pcd_last;
    logic [64:0] exp_cd;
    int         cd_owed;
    pcr_stall = 0; pcd_stall = 0; cd_owed = 0;
    pcr_resp = 0; pcd_data = 0; pcd_last = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        cr_q.delete(); cd_q.delete();
        cd_owed = 0; pcr_stall = 0; pcd_stall = 0;
      end else begin
        if (pcr_stall) begin
          chk("cr_hold_valid", cr_valid_o, 1);
          chk("cr_hold_resp", cr_resp_o, pcr_resp);
        end
        if (pcd_stall) begin
          chk("cd_hold_valid", cd_valid_o, 1);
          chk("cd_hold_data", cd_data_o, pcd_data);
          chk("cd_hold_last", cd_last_o, pcd_last);
        end
`ifndef SNOOP_RESP_CD_OVERLAP_EN
        if (cr_valid_o || cd_valid_o) chk("cr_cd_exclusive", cr_valid_o & cd_valid_o, 0);
`endif
        if (cr_valid_o && cr_ready_i) begin
`ifndef SNOOP_RESP_CD_OVERLAP_EN
          chk("cr_after_cd", cd_owed, 0);
`endif
          chk("cr_expected", cr_q.size() != 0, 1);
          if (cr_q.size() != 0) begin
            exp_cr = cr_q.pop_front();
            chk("cr_resp", cr_resp_o, exp_cr);
            if (exp_cr[0]) cd_owed += NUM_BEATS;
          end
        end
        if (cd_valid_o && cd_ready_i) begin
          chk("cd_expected", cd_q.size() != 0, 1);
          if (cd_q.size() != 0) begin
            exp_cd = cd_q.pop_front();
            exp_last = exp_cd[64];
            chk("cd_data", cd_data_o, exp_cd[63:0]);
            chk("cd_last", cd_last_o, exp_last);
            cd_owed--;
          end
        end
        pcr_stall = cr_valid_o && !cr_ready_i; pcr_resp = cr_resp_o;
        pcd_stall = cd_valid_o && !cd_ready_i; pcd_data = cd_data_o; pcd_last = cd_last_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_cr_valid", cr_valid_o, 0);
    chk("rst_cd_valid", cd_valid_o, 0);
    chk("rst_cr_resp", cr_resp_o, 0);
    chk("rst_cd_data", cd_data_o, 0);
    chk("rst_cd_last", cd_last_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", resp_ready_o, 1);

    // Single data response, both readies high.
    @(posedge clk); #1;
    push_resp(5'b00001, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});
    @(negedge clk);
    chk("t1_cr_valid_n1", cr_valid_o, 1);
    chk("t1_cr_resp", cr_resp_o, 5'b00001);
    @(negedge clk);
    chk("t1_beat0_valid", cd_valid_o, 1);
    chk("t1_beat0_data", cd_data_o, 64'h5555_5555_5555_5555);
    chk("t1_beat0_last", cd_last_o, 0);
    @(negedge clk);
    chk("t1_beat1_data", cd_data_o, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t1_beat1_last", cd_last_o, 1);
    @(negedge clk);
    chk("t1_busy_n4", busy_o, 0);
    chk("t1_count_n4", count_o, 0);

    // CR only, error bit carried through.
    @(posedge clk); #1;
    push_resp(5'b00010, {2{64'hDEAD_BEEF_0000_1111}});
    @(negedge clk);
    chk("t2_count1", count_o, 1);
    chk("t2_cr_resp", cr_resp_o, 5'b00010);
    @(negedge clk);
    chk("t2_count0", count_o, 0);
    chk("t2_no_cd", cd_valid_o, 0);
    wait_idle();

    // Fill with CR stalled; third offer blocked.
    @(posedge clk); #1 cr_ready_i = 1'b0;
    push_resp(5'b01001, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210});
    push_resp(5'b10000, {2{64'h1111_2222_3333_4444}});
    @(negedge clk);
    chk("t3_count_full", count_o, 2);
    chk("t3_ready_full", resp_ready_o, 0);
    @(posedge clk); #1;
    resp_valid_i = 1'b1; resp_cr_i = 5'b00111;
    repeat (3) @(negedge clk);
    chk("t3_still_blocked", resp_ready_o, 0);
    chk("t3_count_held", count_o, 2);
    @(posedge clk); #1 cr_ready_i = 1'b1;
    push_resp(5'b00111, {64'hCAFE_F00D_CAFE_F00D, 64'h0BAD_C0DE_0BAD_C0DE});
    wait_idle();

    // Random CD stalls on a data response followed by a CR-only one.
    @(posedge clk); #1 cd_ready_i = 1'b0;
    push_resp(5'b00001, {64'h9999_8888_7777_6666, 64'h1234_5678_9ABC_DEF0});
    push_resp(5'b01000, {2{64'h0}});
    for (int i = 0; i < 200 && (cr_q.size() + cd_q.size()) != 0; i++) begin
      @(posedge clk); #1 cd_ready_i = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 cd_ready_i = 1'b1;
    wait_idle();

    // Reset between CR handshake and the second CD beat.
    @(posedge clk); #1 cd_ready_i = 1'b0;
    push_resp(5'b00101, {64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5});
    @(negedge clk);
    chk("t5_cr_valid", cr_valid_o, 1);
    @(negedge clk);
    chk("t5_cd_pending", cd_valid_o, 1);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0; cd_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_cr_valid_rst", cr_valid_o, 0);
    chk("t5_cd_valid_rst", cd_valid_o, 0);
    chk("t5_count_rst", count_o, 0);
    chk("t5_ready_rst", resp_ready_o, 1);
    @(posedge clk); #1;
    push_resp(5'b10100, {2{64'h7777_7777_7777_7777}});
    @(negedge clk);
    chk("t5_fresh_cr", cr_valid_o, 1);
    wait_idle();

`ifdef SNOOP_RESP_CD_OVERLAP_EN
    // CD completes while CR is held off; pop only on the CR handshake.
    @(posedge clk); #1 cr_ready_i = 1'b0; cd_ready_i = 1'b1;
    push_resp(5'b00001, {64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF});
    repeat (3) @(negedge clk);
    chk("t6_cd_done", cd_q.size(), 0);
    chk("t6_cd_dropped", cd_valid_o, 0);
    chk("t6_cr_waiting", cr_valid_o, 1);
    chk("t6_not_popped", count_o, 1);
    repeat (2) @(posedge clk);
    #1 cr_ready_i = 1'b1;
    wait_idle();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
